// File: rtl/pattern_generator_ec.sv
// pattern_generator_ec: turns letter requests (E, C, space) into the two-symbol
// {OutputMSB, OutputLSB} stream expected by the EC pattern detector, followed by
// GAP_CYCLES idle symbols. All outputs are registered.
// Optional build macro PATTERN_GEN_SYM_COUNT_EN adds a saturating 16-bit sym_count.
module pattern_generator_ec #(
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        letter_valid,
    input  logic [1:0]  letter_code,
    output logic        letter_ready,
    output logic        OutputMSB,
    output logic        OutputLSB,
    output logic        sym_valid,
    output logic        done,
`ifdef PATTERN_GEN_SYM_COUNT_EN
    output logic [15:0] sym_count,
`endif
    output logic        err
);

    localparam logic [1:0] CodeE     = 2'b00;
    localparam logic [1:0] CodeC     = 2'b01;
    localparam logic [1:0] CodeSpace = 2'b10;
    localparam logic [1:0] CodeRsvd  = 2'b11;
    // Gap counter starts at 1 on entry, so the last gap cycle is when it equals GAP_CYCLES.
    localparam logic [3:0] GapLast   = 4'(GAP_CYCLES);

    typedef enum logic [1:0] {StIdle, StHalf1, StHalf2, StGap} state_e;

    state_e     state_q, state_d;
    logic [1:0] code_q, code_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    logic       ready_q, ready_d;
    logic       msb_q, msb_d;
    logic       lsb_q, lsb_d;
    logic       sv_q, sv_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       accept;

    // Next-state logic: letter sequencing and gap counting.
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        gap_cnt_d = gap_cnt_q;
        err_d     = 1'b0;
        accept    = ready_q && letter_valid;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (letter_code == CodeRsvd) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = StHalf1;
                        code_d  = letter_code;
                    end
                end
            end
            StHalf1: state_d = StHalf2;
            StHalf2: begin
                if (GAP_CYCLES > 0) begin
                    state_d   = StGap;
                    gap_cnt_d = 4'd1;
                end else begin
                    state_d = StIdle;
                end
            end
            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    state_d   = StIdle;
                    gap_cnt_d = 4'd0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode from the upcoming state so every output is a plain register.
    always_comb begin
        msb_d   = 1'b0;
        lsb_d   = 1'b1;
        sv_d    = 1'b0;
        done_d  = 1'b0;
        ready_d = (state_d == StIdle);
        case (state_d)
            StHalf1: begin
                sv_d = 1'b1;
                {msb_d, lsb_d} = (code_d == CodeSpace) ? 2'b01 : 2'b11;
            end
            StHalf2: begin
                sv_d   = 1'b1;
                done_d = 1'b1;
                case (code_d)
                    CodeE:   {msb_d, lsb_d} = 2'b10;
                    CodeC:   {msb_d, lsb_d} = 2'b00;
                    default: {msb_d, lsb_d} = 2'b01;
                endcase
            end
            default: ;
        endcase
    end

    // State and output registers; reset aborts any letter in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            code_q    <= CodeE;
            gap_cnt_q <= 4'd0;
            ready_q   <= 1'b0;
            msb_q     <= 1'b0;
            lsb_q     <= 1'b1;
            sv_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            gap_cnt_q <= gap_cnt_d;
            ready_q   <= ready_d;
            msb_q     <= msb_d;
            lsb_q     <= lsb_d;
            sv_q      <= sv_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign letter_ready = ready_q;
    assign OutputMSB    = msb_q;
    assign OutputLSB    = lsb_q;
    assign sym_valid    = sv_q;
    assign done         = done_q;
    assign err          = err_q;

`ifdef PATTERN_GEN_SYM_COUNT_EN
    logic [15:0] sym_count_q;

    // Saturating count of cycles that carried a letter symbol.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_count_q <= 16'd0;
        end else if (sv_q && (sym_count_q != 16'hFFFF)) begin
            sym_count_q <= sym_count_q + 16'd1;
        end
    end

    assign sym_count = sym_count_q;
`endif

endmodule

// File: tb/tb_pattern_generator_ec.sv
// Directed bench for pattern_generator_ec: main instance with GAP_CYCLES=1 plus
// GAP_CYCLES=0 and GAP_CYCLES=15 instances for acceptance spacing.
module tb_pattern_generator_ec;

    logic       clk;
    logic       rst_n;
    logic       letter_valid;
    logic [1:0] letter_code;

    logic ready1, msb1, lsb1, sv1, done1, err1;
    logic ready0, msb0, lsb0, sv0, done0, err0;
    logic ready15, msb15, lsb15, sv15, done15, err15;
`ifdef PATTERN_GEN_SYM_COUNT_EN
    logic [15:0] cnt1, cnt0, cnt15;
`endif

    int checks = 0;
    int errors = 0;

    pattern_generator_ec #(.GAP_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .letter_valid(letter_valid), .letter_code(letter_code),
        .letter_ready(ready1), .OutputMSB(msb1), .OutputLSB(lsb1), .sym_valid(sv1),
`ifdef PATTERN_GEN_SYM_COUNT_EN
        .sym_count(cnt1),
`endif
        .done(done1), .err(err1)
    );

    pattern_generator_ec #(.GAP_CYCLES(0)) dut_gap0 (
        .clk(clk), .rst_n(rst_n), .letter_valid(letter_valid), .letter_code(letter_code),
        .letter_ready(ready0), .OutputMSB(msb0), .OutputLSB(lsb0), .sym_valid(sv0),
`ifdef PATTERN_GEN_SYM_COUNT_EN
        .sym_count(cnt0),
`endif
        .done(done0), .err(err0)
    );

    pattern_generator_ec #(.GAP_CYCLES(15)) dut_gap15 (
        .clk(clk), .rst_n(rst_n), .letter_valid(letter_valid), .letter_code(letter_code),
        .letter_ready(ready15), .OutputMSB(msb15), .OutputLSB(lsb15), .sym_valid(sv15),
`ifdef PATTERN_GEN_SYM_COUNT_EN
        .sym_count(cnt15),
`endif
        .done(done15), .err(err15)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Observed vector: {letter_ready, OutputMSB, OutputLSB, sym_valid, done, err}
    function automatic logic [5:0] obs();
        return {ready1, msb1, lsb1, sv1, done1, err1};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       valid;
        logic [1:0] code;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[15];
    int   acc0[$];
    int   acc15[$];

    initial begin
        logic [1:0] prev_sym;
        logic [1:0] cur_sym;
        logic       first_det;
        logic       second_det;
        int         done_seen;
        int         sv_seen;
        int         d;

        // Cycle 0 is the first cycle after reset release.
        vecs[0]  = '{1'b1, 2'b00, 6'b001000}; // request ignored, not ready yet
        vecs[1]  = '{1'b1, 2'b00, 6'b101000}; // E accepted
        vecs[2]  = '{1'b1, 2'b01, 6'b011100}; // E half 1, C held
        vecs[3]  = '{1'b1, 2'b01, 6'b010110}; // E half 2 + done
        vecs[4]  = '{1'b1, 2'b01, 6'b001000}; // gap
        vecs[5]  = '{1'b1, 2'b01, 6'b101000}; // C accepted
        vecs[6]  = '{1'b0, 2'b00, 6'b011100}; // C half 1
        vecs[7]  = '{1'b0, 2'b00, 6'b000110}; // C half 2 + done
        vecs[8]  = '{1'b0, 2'b00, 6'b001000}; // gap
        vecs[9]  = '{1'b1, 2'b11, 6'b101000}; // reserved accepted
        vecs[10] = '{1'b1, 2'b10, 6'b101001}; // err pulse, space accepted
        vecs[11] = '{1'b0, 2'b00, 6'b001100}; // space half 1
        vecs[12] = '{1'b0, 2'b00, 6'b001110}; // space half 2 + done
        vecs[13] = '{1'b0, 2'b00, 6'b001000}; // gap
        vecs[14] = '{1'b0, 2'b00, 6'b101000}; // idle, ready

        rst_n        = 1'b0;
        letter_valid = 1'b0;
        letter_code  = 2'b00;
        prev_sym     = 2'b01;
        first_det    = 1'b0;
        second_det   = 1'b0;

        repeat (3) tick();
        check("reset_state", 32'(obs()), 32'(6'b001000));
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            letter_valid = vecs[i].valid;
            letter_code  = vecs[i].code;
            check($sformatf("vec[%0d]", i), 32'(obs()), 32'(vecs[i].exp));
            // Minimal EC detector fed by the symbol stream.
            cur_sym = {msb1, lsb1};
            if (prev_sym == 2'b11 && cur_sym == 2'b10) first_det = 1'b1;
            if (first_det && prev_sym == 2'b11 && cur_sym == 2'b00) second_det = 1'b1;
            prev_sym = cur_sym;
            tick();
        end
        check("first_letter_detected", 32'(first_det), 32'd1);
        check("second_letter_detected", 32'(second_det), 32'd1);
`ifdef PATTERN_GEN_SYM_COUNT_EN
        check("sym_count_3_letters", 32'(cnt1), 32'd6);
`endif

        // Reset mid-letter: letter aborted before its second symbol.
        letter_valid = 1'b1;
        letter_code  = 2'b00;
        tick();
        letter_valid = 1'b0;
        check("midletter_half1", 32'(obs()), 32'(6'b011100));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", 32'(obs()), 32'(6'b001000));
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rst_hold[%0d]", i), 32'(obs()), 32'(6'b001000));
        end
        rst_n = 1'b1;
        check("ready_low_after_release", 32'(ready1), 32'd0);
        done_seen = 0;
        sv_seen   = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done1) done_seen++;
            if (sv1) sv_seen++;
            if (i == 0) check("ready_first_edge", 32'(ready1), 32'd1);
        end
        check("no_done_after_abort", 32'(done_seen), 32'd0);
        check("no_resume_after_abort", 32'(sv_seen), 32'd0);

        // Gap extremes: record acceptance cycles with E held valid.
        letter_valid = 1'b1;
        letter_code  = 2'b00;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (ready0) acc0.push_back(cyc);
            if (ready15) acc15.push_back(cyc);
            tick();
        end
        check("gap0_enough_accepts", 32'(acc0.size() >= 3), 32'd1);
        check("gap15_enough_accepts", 32'(acc15.size() >= 3), 32'd1);
        for (int k = 1; k < 3; k++) begin
            d = (acc0.size() > k) ? acc0[k] - acc0[k-1] : -1;
            check($sformatf("gap0_spacing[%0d]", k), 32'(d), 32'd3);
            d = (acc15.size() > k) ? acc15[k] - acc15[k-1] : -1;
            check($sformatf("gap15_spacing[%0d]", k), 32'(d), 32'd18);
        end

`ifdef PATTERN_GEN_SYM_COUNT_EN
        // Preload near max, keep letters flowing, expect saturation.
        force dut.sym_count_q = 16'hFFFD;
        tick();
        release dut.sym_count_q;
        repeat (12) tick();
        check("sym_count_saturate", 32'(cnt1), 32'h0000FFFF);
`endif

        letter_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
